// File: rtl/reg_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter_if
// Description : Bundles the requester-side and register-slave-side signals
//               of reg_bus_arbiter.
//               - master modport: the arbiter's view. It serves the
//                 requesters and drives the shared register bus.
//               - slave modport: the environment's view. This covers the
//                 requesters plus the register slave.
// Ports       : reqValid/reqRead/reqAddress/reqWriteData  (requesters -> arb)
//               reqAck/reqError/reqReadData              (arb -> requesters)
//               registerSelect/Read/Address/WriteData    (arb -> slave)
//               registerAck/Error/ReadData               (slave -> arb)
//               timeoutEvent                             (arb -> environment)
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    reqValid;
  logic [NUM_REQ-1:0]    reqRead;
  logic [NUM_REQ*30-1:0] reqAddress;
  logic [NUM_REQ*32-1:0] reqWriteData;
  logic [NUM_REQ-1:0]    reqAck;
  logic                  reqError;
  logic [31:0]           reqReadData;
  logic                  registerSelect;
  logic                  registerRead;
  logic [29:0]           registerAddress;
  logic [31:0]           registerWriteData;
  logic                  registerAck;
  logic                  registerError;
  logic [31:0]           registerReadData;
  logic                  timeoutEvent;

  modport master (
    input  reqValid, reqRead, reqAddress, reqWriteData,
    output reqAck, reqError, reqReadData,
    output registerSelect, registerRead, registerAddress, registerWriteData,
    input  registerAck, registerError, registerReadData,
    output timeoutEvent
  );

  modport slave (
    output reqValid, reqRead, reqAddress, reqWriteData,
    input  reqAck, reqError, reqReadData,
    input  registerSelect, registerRead, registerAddress, registerWriteData,
    output registerAck, registerError, registerReadData,
    input  timeoutEvent
  );
endinterface
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_arbiter
// Description : Round-robin arbiter that shares one register-slave bus
//               between NUM_REQ requesters. Each grant runs exactly one bus
//               transaction: IDLE -> BUSY (select held until the slave acks)
//               -> GAP (select held low) -> IDLE.
// Ports       : clock  - single clock
//               reset  - asynchronous, active-high reset
//               bus    - reg_bus_arbiter_if.master. It carries the requester
//                        handshake, the register-slave bus and timeoutEvent.
// Parameters  : NUM_REQ (2..8), GAP_CYCLES (>= 2),
//               TIMEOUT_CYCLES (only present with REG_ARB_TIMEOUT_EN)
// Option      : `define REG_ARB_TIMEOUT_EN adds a BUSY-cycle watchdog. When
//               it expires, the transaction is aborted with an error
//               response. Without the macro, BUSY waits forever and
//               timeoutEvent is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2
`ifdef REG_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  wire logic          clock,
  input  wire logic          reset,
  reg_bus_arbiter_if.master  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               select_q, select_d;
  logic               read_q, read_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
`ifdef REG_ARB_TIMEOUT_EN
  logic [15:0]        busy_cnt_q, busy_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // First requesting index at or after the pointer, wrapping modulo NUM_REQ.
  logic             found;
  logic [PTR_W-1:0] sel;
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && bus.reqValid[(int'(ptr_q) + off) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    gap_d    = gap_q;
    select_d = select_q;
    read_d   = read_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;           // reqAck is a single-cycle pulse
    err_d    = err_q;
    rdata_d  = rdata_q;      // read data holds until the next completion
`ifdef REG_ARB_TIMEOUT_EN
    busy_cnt_d = busy_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = sel;
          ptr_d    = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
          read_d   = bus.reqRead[sel];
          addr_d   = bus.reqAddress[int'(sel)*30 +: 30];
          wdata_d  = bus.reqWriteData[int'(sel)*32 +: 32];
          select_d = 1'b1;
          state_d  = BUSY;
`ifdef REG_ARB_TIMEOUT_EN
          busy_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        // registerAck has priority over an expiring watchdog in the same cycle.
        if (bus.registerAck) begin
          select_d       = 1'b0;
          read_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d          = bus.registerError;
          rdata_d        = bus.registerReadData;
          gap_d          = GAP_W'(GAP_CYCLES - 1);
          state_d        = GAP;
        end
`ifdef REG_ARB_TIMEOUT_EN
        // The counter holds the number of BUSY cycles already completed.
        // Abort at the end of the TIMEOUT_CYCLES-th BUSY cycle.
        else if (busy_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          select_d       = 1'b0;
          read_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          rdata_d        = 32'h0;
          timeout_d      = 1'b1;
          gap_d          = GAP_W'(GAP_CYCLES - 1);
          state_d        = GAP;
        end else begin
          busy_cnt_d = busy_cnt_q + 16'd1;
        end
`endif
      end
      GAP: begin
        // reqValid is deliberately not looked at here.
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      gap_q    <= '0;
      select_q <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      gap_q    <= gap_d;
      select_q <= select_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef REG_ARB_TIMEOUT_EN
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.reqAck            = ack_q;
  assign bus.reqError          = err_q;
  assign bus.reqReadData       = rdata_q;
  assign bus.registerSelect    = select_q;
  assign bus.registerRead      = read_q;
  assign bus.registerAddress   = addr_q;
  assign bus.registerWriteData = wdata_q;
`ifdef REG_ARB_TIMEOUT_EN
  assign bus.timeoutEvent      = timeout_q;
`else
  assign bus.timeoutEvent      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_arbiter
// Description : Self-checking bench for reg_bus_arbiter. Expected responses
//               are pushed to a scoreboard queue when a request is issued.
//               They are popped and compared when reqAck appears.
//               Inputs are driven and outputs sampled on the falling edge.
//               Build with REG_ARB_TIMEOUT_EN to add the watchdog scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 8;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clock = ~clock;

  reg_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bif ();

  reg_bus_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES)
`ifdef REG_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.master)
  );

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic set_req(input int i, input logic rd, input logic [29:0] a, input logic [31:0] wd);
    bif.reqRead[i]              = rd;
    bif.reqAddress[i*30 +: 30]  = a;
    bif.reqWriteData[i*32 +: 32] = wd;
  endtask

  // Counts falling edges until registerSelect is seen high (bounded).
  task automatic wait_select(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(negedge clock);
      n++;
      if (bif.registerSelect === 1'b1) ok = 1'b1;
    end
  endtask

  // Called at the falling edge where select was first seen. The slave acks
  // 'lat' cycles later. Returns at the edge where reqAck should be visible.
  task automatic slave_ack(input int lat, input logic [31:0] d, input logic er);
    repeat (lat - 1) @(negedge clock);
    bif.registerAck      = 1'b1;
    bif.registerReadData = d;
    bif.registerError    = er;
    @(negedge clock);
    bif.registerAck      = 1'b0;
    bif.registerError    = 1'b0;
    bif.registerReadData = 32'hBAD0_BAD0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pop_exp(output exp_t x);
    if (sb.size() == 0) begin
      x = '{idx: 0, err: 1'b0, data: 32'h0, tmo: 1'b0};
      $display("FAIL scoreboard underflow");
      miscompares++;
    end else begin
      x = sb.pop_front();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset                 = 1'b1;
    bif.reqValid          = '0;
    bif.reqRead           = '0;
    bif.reqAddress        = '0;
    bif.reqWriteData      = '0;
    bif.registerAck       = 1'b0;
    bif.registerError     = 1'b0;
    bif.registerReadData  = 32'h0;
    repeat (3) @(negedge clock);
    vectors++; if (bif.registerSelect !== 1'b0) begin miscompares++; $display("FAIL rst_select got %b want 0", bif.registerSelect); end
    vectors++; if (bif.registerRead !== 1'b0) begin miscompares++; $display("FAIL rst_read got %b want 0", bif.registerRead); end
    vectors++; if (bif.registerAddress !== 30'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", bif.registerAddress); end
    vectors++; if (bif.registerWriteData !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", bif.registerWriteData); end
    vectors++; if (bif.reqAck !== 4'b0000) begin miscompares++; $display("FAIL rst_ack got %b want 0000", bif.reqAck); end
    vectors++; if ({bif.reqError, bif.reqReadData} !== 33'h0) begin miscompares++; $display("FAIL rst_resp got %b/%h want 0/0", bif.reqError, bif.reqReadData); end
    vectors++; if (bif.timeoutEvent !== 1'b0) begin miscompares++; $display("FAIL rst_tmo got %b want 0", bif.timeoutEvent); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int n; bit ok;
    set_req(0, 1'b1, 30'h10, 32'h0);
    bif.reqValid = 4'b0001;
    sb.push_back('{idx: 0, err: 1'b0, data: 32'hA5A5_0001, tmo: 1'b0});
    wait_select(n, ok);
    vectors++; if (!ok || n != 1) begin miscompares++; $display("FAIL rd_grant_latency got %0d (seen=%0d) want 1", n, ok); end
    vectors++; if (bif.registerAddress !== 30'h10) begin miscompares++; $display("FAIL rd_addr got %h want 10", bif.registerAddress); end
    vectors++; if (bif.registerRead !== 1'b1) begin miscompares++; $display("FAIL rd_strobe got %b want 1", bif.registerRead); end
    slave_ack(3, 32'hA5A5_0001, 1'b0);
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (bif.reqAck !== 4'(1 << e.idx)) begin miscompares++; $display("FAIL rd_ack got %b want %b", bif.reqAck, 4'(1 << e.idx)); end
    vectors++; if (bif.reqReadData !== e.data || bif.reqError !== e.err) begin miscompares++; $display("FAIL rd_resp got %b/%h want %b/%h", bif.reqError, bif.reqReadData, e.err, e.data); end
    vectors++; if (bif.registerSelect !== 1'b0 || bif.registerRead !== 1'b0) begin miscompares++; $display("FAIL rd_release got %b%b want 00", bif.registerSelect, bif.registerRead); end
    vectors++; if (bif.timeoutEvent !== 1'b0) begin miscompares++; $display("FAIL rd_tmo got %b want 0", bif.timeoutEvent); end
    @(negedge clock);
    vectors++; if (bif.reqAck !== 4'b0000) begin miscompares++; $display("FAIL rd_ack_width got %b want 0000", bif.reqAck); end
    vectors++; if (bif.reqReadData !== 32'hA5A5_0001) begin miscompares++; $display("FAIL rd_data_hold got %h want a5a50001", bif.reqReadData); end
    repeat (GAP_CYCLES + 1) @(negedge clock);
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'(i % 2), 30'h100 + 30'(i), 32'h5000_0000 + 32'(i));
    bif.reqValid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{idx: k % NUM_REQ, err: 1'b0, data: 32'hC0DE_0000 + 32'(k), tmo: 1'b0});
      wait_select(n, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_select_timeout k=%0d waited %0d", k, n); end
      // Select-low run: the GAP_CYCLES GAP cycles plus the IDLE arbitration cycle.
      if (k > 0) begin
        vectors++; if (n != GAP_CYCLES + 1) begin miscompares++; $display("FAIL rr_gap k=%0d got %0d low cycles want %0d", k, n, GAP_CYCLES + 1); end
      end
      vectors++; if (bif.registerAddress !== 30'h100 + 30'(k % NUM_REQ)) begin miscompares++; $display("FAIL rr_addr k=%0d got %h want %h", k, bif.registerAddress, 30'h100 + 30'(k % NUM_REQ)); end
      slave_ack(1 + k % 3, 32'hC0DE_0000 + 32'(k), 1'b0);
      pop_exp(e);
      vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqReadData !== e.data) begin miscompares++; $display("FAIL rr_ack k=%0d got %b/%h want %b/%h", k, bif.reqAck, bif.reqReadData, 4'(1 << e.idx), e.data); end
    end
    bif.reqValid = 4'b0000;
    repeat (GAP_CYCLES + 2) @(negedge clock);
  endtask

  task automatic test_write_error();
    int n; bit ok;
    set_req(2, 1'b0, 30'h3FF, 32'hDEAD_0002);
    bif.reqValid = 4'b0100;
    sb.push_back('{idx: 2, err: 1'b1, data: 32'h1234_5678, tmo: 1'b0});
    wait_select(n, ok);
    vectors++; if (!ok || bif.registerAddress !== 30'h3FF || bif.registerRead !== 1'b0) begin miscompares++; $display("FAIL wr_cmd got sel=%0d addr=%h rd=%b want 1/3ff/0", ok, bif.registerAddress, bif.registerRead); end
    @(negedge clock);
    vectors++; if (bif.registerWriteData !== 32'hDEAD_0002 || bif.registerSelect !== 1'b1) begin miscompares++; $display("FAIL wr_busy_hold got %b/%h want 1/dead0002", bif.registerSelect, bif.registerWriteData); end
    slave_ack(1, 32'h1234_5678, 1'b1);
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqError !== e.err || bif.reqReadData !== e.data) begin miscompares++; $display("FAIL wr_err_resp got %b/%b/%h want %b/%b/%h", bif.reqAck, bif.reqError, bif.reqReadData, 4'(1 << e.idx), e.err, e.data); end
    repeat (GAP_CYCLES + 2) @(negedge clock);
  endtask

  task automatic test_spurious_ack();
    int n; bit ok;
    bif.registerAck      = 1'b1;
    bif.registerError    = 1'b1;
    bif.registerReadData = 32'hFFFF_FFFF;
    @(negedge clock);
    bif.registerAck   = 1'b0;
    bif.registerError = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++; if (bif.reqAck !== 4'b0000 || bif.registerSelect !== 1'b0) begin miscompares++; $display("FAIL spur_idle c=%0d got ack=%b sel=%b want 0000/0", c, bif.reqAck, bif.registerSelect); end
      @(negedge clock);
    end
    set_req(1, 1'b1, 30'h22, 32'h0);
    bif.reqValid = 4'b0010;
    sb.push_back('{idx: 1, err: 1'b0, data: 32'h0000_1111, tmo: 1'b0});
    wait_select(n, ok);
    vectors++; if (!ok || n != 1 || bif.registerAddress !== 30'h22) begin miscompares++; $display("FAIL spur_then_req got lat=%0d addr=%h want 1/22", n, bif.registerAddress); end
    slave_ack(2, 32'h0000_1111, 1'b0);
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqReadData !== e.data || bif.reqError !== e.err) begin miscompares++; $display("FAIL spur_resp got %b/%b/%h want %b/%b/%h", bif.reqAck, bif.reqError, bif.reqReadData, 4'(1 << e.idx), e.err, e.data); end
    repeat (GAP_CYCLES + 2) @(negedge clock);
  endtask

  task automatic test_reset_busy();
    int n; bit ok;
    set_req(0, 1'b1, 30'h0A0, 32'h0);
    set_req(3, 1'b1, 30'h0A3, 32'h0);
    set_req(2, 1'b0, 30'h0A2, 32'h7777_7777);
    bif.reqValid = 4'b0100;
    wait_select(n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rb_busy_entry got sel=%0d want 1", ok); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (bif.registerSelect !== 1'b0 || bif.reqAck !== 4'b0000) begin miscompares++; $display("FAIL rb_async_drop got sel=%b ack=%b want 0/0000", bif.registerSelect, bif.reqAck); end
    @(negedge clock);
    bif.reqValid = 4'b1001;
    @(negedge clock);
    reset = 1'b0;
    sb.push_back('{idx: 0, err: 1'b0, data: 32'h0BAD_F00D, tmo: 1'b0});
    wait_select(n, ok);
    vectors++; if (!ok || n != 1 || bif.registerAddress !== 30'h0A0) begin miscompares++; $display("FAIL rb_first_grant got lat=%0d addr=%h want 1/0a0", n, bif.registerAddress); end
    slave_ack(1, 32'h0BAD_F00D, 1'b0);
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqReadData !== e.data) begin miscompares++; $display("FAIL rb_resp got %b/%h want %b/%h", bif.reqAck, bif.reqReadData, 4'(1 << e.idx), e.data); end
    repeat (GAP_CYCLES + 2) @(negedge clock);
  endtask

`ifdef REG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok; int hi;
    set_req(3, 1'b1, 30'h0C3, 32'h0);
    bif.reqValid = 4'b1000;
    sb.push_back('{idx: 3, err: 1'b1, data: 32'h0, tmo: 1'b1});
    wait_select(n, ok);
    hi = ok ? 1 : 0;
    while (ok && hi < 50) begin
      @(negedge clock);
      if (bif.registerSelect === 1'b1) hi++; else break;
    end
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (hi != TIMEOUT_CYCLES) begin miscompares++; $display("FAIL to_busy_len got %0d want %0d", hi, TIMEOUT_CYCLES); end
    vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqError !== e.err || bif.reqReadData !== e.data) begin miscompares++; $display("FAIL to_resp got %b/%b/%h want %b/%b/%h", bif.reqAck, bif.reqError, bif.reqReadData, 4'(1 << e.idx), e.err, e.data); end
    vectors++; if (bif.timeoutEvent !== e.tmo) begin miscompares++; $display("FAIL to_event got %b want %b", bif.timeoutEvent, e.tmo); end
    @(negedge clock);
    vectors++; if (bif.timeoutEvent !== 1'b0 || bif.reqAck !== 4'b0000) begin miscompares++; $display("FAIL to_pulse_width got %b/%b want 0/0000", bif.timeoutEvent, bif.reqAck); end
    repeat (GAP_CYCLES + 1) @(negedge clock);
  endtask

  task automatic test_timeout_race();
    int n; bit ok;
    bif.reqValid = 4'b1000;
    sb.push_back('{idx: 3, err: 1'b0, data: 32'h600D_0008, tmo: 1'b0});
    wait_select(n, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL race_select got sel=%0d want 1", ok); end
    slave_ack(TIMEOUT_CYCLES, 32'h600D_0008, 1'b0);
    bif.reqValid = 4'b0000;
    pop_exp(e);
    vectors++; if (bif.reqAck !== 4'(1 << e.idx) || bif.reqError !== e.err || bif.reqReadData !== e.data) begin miscompares++; $display("FAIL race_resp got %b/%b/%h want %b/%b/%h", bif.reqAck, bif.reqError, bif.reqReadData, 4'(1 << e.idx), e.err, e.data); end
    vectors++; if (bif.timeoutEvent !== e.tmo) begin miscompares++; $display("FAIL race_event got %b want %b", bif.timeoutEvent, e.tmo); end
    repeat (GAP_CYCLES + 2) @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_error();
    test_spurious_ack();
    test_reset_busy();
`ifdef REG_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
